// File: rtl/ltm_timing_pkg.sv
// rtl/ltm_timing_pkg.sv - LTM panel timing defaults and display reader state encoding
package ltm_timing_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FRONT  = 40;
    localparam int H_SYNC   = 1;
    localparam int H_BACK   = 215;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 1;
    localparam int V_BACK   = 34;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam int DISPLAY_WIDTH  = H_ACTIVE;
    localparam int DISPLAY_HEIGHT = V_ACTIVE;

    localparam logic [23:0] BLANK_RGB = 24'h000000;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } disp_state_e;

    // Counter width that can also represent the total itself (end-of-region compares).
    function automatic int cnt_width(input int total);
        return $clog2(total + 1);
    endfunction

endpackage

// File: rtl/ltm_timing_gen.sv
// rtl/ltm_timing_gen.sv - LTM H/V counters with sync, data-enable and frame-position decode
module ltm_timing_gen
    import ltm_timing_pkg::*;
#(
    parameter int H_ACT = H_ACTIVE,
    parameter int H_FP  = H_FRONT,
    parameter int H_SW  = H_SYNC,
    parameter int H_BP  = H_BACK,
    parameter int V_ACT = V_ACTIVE,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_BP  = V_BACK
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic hd_o,
    output logic vd_o,
    output logic den_o,
    output logic first_px_o,
    output logic origin_o,
    output logic frame_end_o
);

    localparam int HT = H_SW + H_BP + H_ACT + H_FP;
    localparam int VT = V_SW + V_BP + V_ACT + V_FP;
    localparam int HW = cnt_width(HT);
    localparam int VW = cnt_width(VT);

    localparam logic [HW-1:0] H_LAST      = HW'(HT - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SW);
    localparam logic [HW-1:0] H_ACT_START = HW'(H_SW + H_BP);
    localparam logic [HW-1:0] H_ACT_END   = HW'(H_SW + H_BP + H_ACT);
    localparam logic [VW-1:0] V_LAST      = VW'(VT - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SW);
    localparam logic [VW-1:0] V_ACT_START = VW'(V_SW + V_BP);
    localparam logic [VW-1:0] V_ACT_END   = VW'(V_SW + V_BP + V_ACT);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_wrap, v_wrap;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Region order within a line/frame: sync, back porch, active, front porch.
    assign hd_o        = (h_cnt_q >= H_SYNC_END);
    assign vd_o        = (v_cnt_q >= V_SYNC_END);
    assign den_o       = (h_cnt_q >= H_ACT_START) && (h_cnt_q < H_ACT_END) &&
                         (v_cnt_q >= V_ACT_START) && (v_cnt_q < V_ACT_END);
    assign first_px_o  = (h_cnt_q == H_ACT_START) && (v_cnt_q == V_ACT_START);
    assign origin_o    = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign frame_end_o = h_wrap && v_wrap;

endmodule

// File: rtl/ltm_disp_reader.sv
// rtl/ltm_disp_reader.sv - display-side DISP_FIFO reader driving registered LTM RGB and syncs
module ltm_disp_reader
    import ltm_timing_pkg::*;
#(
    parameter int H_ACT = H_ACTIVE,
    parameter int H_FP  = H_FRONT,
    parameter int H_SW  = H_SYNC,
    parameter int H_BP  = H_BACK,
    parameter int V_ACT = V_ACTIVE,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_BP  = V_BACK
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [23:0] iFIFO_DATA,
    input  logic        iFIFO_EMPTY,
    output logic        oFIFO_RD,
    input  logic        iCLR_ERR,
    output logic [7:0]  oLCD_R,
    output logic [7:0]  oLCD_G,
    output logic [7:0]  oLCD_B,
    output logic        oHD,
    output logic        oVD,
    output logic        oDEN,
    output logic        oFRAME_START,
    output logic        oUNDERFLOW
);

    logic hd, vd, den, first_px, origin, frame_end;

    ltm_timing_gen #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
    ) u_timing (
        .clk_i       (CLK),
        .rst_ni      (RESET_N),
        .hd_o        (hd),
        .vd_o        (vd),
        .den_o       (den),
        .first_px_o  (first_px),
        .origin_o    (origin),
        .frame_end_o (frame_end)
    );

    disp_state_e state_q, state_d;
    logic        miss_q, miss_d;
    logic        uf_q, uf_d;
    logic        running, rd, starve;

    // Stage 1 lines up with the cycle the FIFO q is valid; stage 2 is the output register.
    logic        vld1_q, den1_q, hd1_q, vd1_q, fs1_q;
    logic        den2_q, hd2_q, vd2_q, fs2_q;
    logic [23:0] rgb_q;

    assign running = (state_q == RUN);
    assign rd      = running & den & ~iFIFO_EMPTY;
    assign starve  = running & den & iFIFO_EMPTY;

    always_comb begin
        state_d = state_q;
        miss_d  = miss_q | starve;
        uf_d    = uf_q;
        case (state_q)
            WAIT_SYNC: begin
                if (origin && !iFIFO_EMPTY) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A frame that lost pixels is abandoned at its end so the next one starts aligned.
                if (frame_end && miss_d) begin
                    state_d = WAIT_SYNC;
                    miss_d  = 1'b0;
                end
            end
            default: state_d = WAIT_SYNC;
        endcase
        if (starve) begin
            uf_d = 1'b1;
        end else if (iCLR_ERR) begin
            uf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= WAIT_SYNC;
            miss_q  <= 1'b0;
            uf_q    <= 1'b0;
            vld1_q  <= 1'b0;
            den1_q  <= 1'b0;
            hd1_q   <= 1'b1;
            vd1_q   <= 1'b1;
            fs1_q   <= 1'b0;
            den2_q  <= 1'b0;
            hd2_q   <= 1'b1;
            vd2_q   <= 1'b1;
            fs2_q   <= 1'b0;
            rgb_q   <= BLANK_RGB;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            uf_q    <= uf_d;
            vld1_q  <= rd;
            den1_q  <= den;
            hd1_q   <= hd;
            vd1_q   <= vd;
            fs1_q   <= first_px & running;
            den2_q  <= den1_q;
            hd2_q   <= hd1_q;
            vd2_q   <= vd1_q;
            fs2_q   <= fs1_q;
            rgb_q   <= (den1_q && vld1_q) ? iFIFO_DATA : BLANK_RGB;
        end
    end

    assign oFIFO_RD     = rd;
    assign oLCD_R       = rgb_q[23:16];
    assign oLCD_G       = rgb_q[15:8];
    assign oLCD_B       = rgb_q[7:0];
    assign oHD          = hd2_q;
    assign oVD          = vd2_q;
    assign oDEN         = den2_q;
    assign oFRAME_START = fs2_q;
    assign oUNDERFLOW   = uf_q;

endmodule

// File: tb/tb_ltm_disp_reader.sv
// tb/tb_ltm_disp_reader.sv - scoreboard bench for ltm_disp_reader on a reduced panel geometry
module tb_ltm_disp_reader;

    localparam int HA = 8, HF = 3, HS = 1, HB = 4;
    localparam int VA = 4, VF = 2, VS = 1, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic        den;
        logic        hd;
        logic        vd;
        logic        fs;
        logic [23:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic [23:0] iFIFO_DATA;
    logic        iFIFO_EMPTY;
    logic        oFIFO_RD;
    logic        iCLR_ERR;
    logic [7:0]  oLCD_R, oLCD_G, oLCD_B;
    logic        oHD, oVD, oDEN, oFRAME_START, oUNDERFLOW;

    always #5 clk = ~clk;

    ltm_disp_reader #(
        .H_ACT(HA), .H_FP(HF), .H_SW(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SW(VS), .V_BP(VB)
    ) dut (
        .CLK          (clk),
        .RESET_N      (RESET_N),
        .iFIFO_DATA   (iFIFO_DATA),
        .iFIFO_EMPTY  (iFIFO_EMPTY),
        .oFIFO_RD     (oFIFO_RD),
        .iCLR_ERR     (iCLR_ERR),
        .oLCD_R       (oLCD_R),
        .oLCD_G       (oLCD_G),
        .oLCD_B       (oLCD_B),
        .oHD          (oHD),
        .oVD          (oVD),
        .oDEN         (oDEN),
        .oFRAME_START (oFRAME_START),
        .oUNDERFLOW   (oUNDERFLOW)
    );

    int          vectors = 0;
    int          misc = 0;
    exp_t        exp_q[$];
    logic [23:0] fifo_q[$];
    logic [23:0] next_word = 24'h0;
    bit          feed = 1'b0;
    bit          rand_data = 1'b0;
    bit          mon_en = 1'b0;
    int          pos_m = 0;
    bit          run_m = 1'b0;
    bit          miss_m = 1'b0;
    bit          uf_m = 1'b0;
    int          frame_reads = 0;
    int          den_cnt = 0;
    int          fs_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            misc++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t reset_entry();
        exp_t e;
        e.den = 1'b0; e.hd = 1'b1; e.vd = 1'b1; e.fs = 1'b0; e.rgb = 24'h0;
        return e;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"},  32'(oFIFO_RD), 32'd0);
        chk({tag, "_rgb"}, 32'({oLCD_R, oLCD_G, oLCD_B}), 32'd0);
        chk({tag, "_hd"},  32'(oHD), 32'd1);
        chk({tag, "_vd"},  32'(oVD), 32'd1);
        chk({tag, "_den"}, 32'(oDEN), 32'd0);
        chk({tag, "_fs"},  32'(oFRAME_START), 32'd0);
        chk({tag, "_uf"},  32'(oUNDERFLOW), 32'd0);
    endtask

    // One pixel clock: model the cycle, queue the response due two clocks later,
    // then act as the FIFO at the edge and apply the next cycle's inputs (fe/clr).
    task automatic step(input bit fe, input bit clr);
        exp_t e;
        int   h, v;
        bit   act, rd_m, empty_s, clr_s, rd_s, was_run;
        @(negedge clk);
        h       = pos_m % HT;
        v       = pos_m / HT;
        empty_s = iFIFO_EMPTY;
        clr_s   = iCLR_ERR;
        rd_s    = oFIFO_RD;
        act     = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        rd_m    = run_m && act && !empty_s;
        chk("rdreq", 32'(rd_s), 32'(rd_m));
        chk("underflow", 32'(oUNDERFLOW), 32'(uf_m));
        if (rd_s) frame_reads++;
        if (oDEN) den_cnt++;
        if (oFRAME_START) fs_cnt++;
        e.den = act;
        e.hd  = (h >= HS);
        e.vd  = (v >= VS);
        e.fs  = run_m && (h == HS + HB) && (v == VS + VB);
        e.rgb = rd_m ? fifo_q[0] : 24'h0;
        exp_q.push_back(e);
        was_run = run_m;
        if (was_run && act && empty_s) uf_m = 1'b1;
        else if (clr_s) uf_m = 1'b0;
        if (!was_run) begin
            if (pos_m == 0 && !empty_s) run_m = 1'b1;
        end else begin
            if (act && empty_s) miss_m = 1'b1;
            if (pos_m == FT - 1 && miss_m) begin
                run_m  = 1'b0;
                miss_m = 1'b0;
            end
        end
        pos_m = (pos_m + 1) % FT;
        @(posedge clk);
        #1;
        if (rd_s && fifo_q.size() > 0) iFIFO_DATA = fifo_q.pop_front();
        if (feed) begin
            while (fifo_q.size() < 4) begin
                fifo_q.push_back(rand_data ? 24'($urandom) : next_word);
                next_word++;
            end
        end
        iFIFO_EMPTY = fe || (fifo_q.size() == 0);
        iCLR_ERR    = clr;
    endtask

    task automatic wait_run_at_origin(input string tag);
        int n = 0;
        while (!(run_m && pos_m == 0) && n < 3 * FT) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 3 * FT), 32'd1);
    endtask

    initial begin
        exp_t e;
        int   tgt;
        RESET_N     = 1'b0;
        iFIFO_DATA  = 24'h0;
        iFIFO_EMPTY = 1'b1;
        iCLR_ERR    = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_underrun", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("den", 32'(oDEN), 32'(e.den));
                        chk("hd",  32'(oHD), 32'(e.hd));
                        chk("vd",  32'(oVD), 32'(e.vd));
                        chk("frame_start", 32'(oFRAME_START), 32'(e.fs));
                        chk("rgb", 32'({oLCD_R, oLCD_G, oLCD_B}), 32'(e.rgb));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        exp_q.push_back(reset_entry());
        exp_q.push_back(reset_entry());
        mon_en  = 1'b1;
        RESET_N = 1'b1;

        // FIFO permanently empty: syncs only, no reads, blank RGB.
        repeat (2 * FT) step(1'b0, 1'b0);

        // Incrementing pattern, FIFO kept non-empty.
        feed = 1'b1;
        wait_run_at_origin("run_start");
        frame_reads = 0; den_cnt = 0; fs_cnt = 0;
        repeat (FT) step(1'b0, 1'b0);
        chk("reads_per_frame", 32'(frame_reads), 32'(HA * VA));
        chk("den_per_frame", 32'(den_cnt), 32'(HA * VA));
        chk("fs_per_frame", 32'(fs_cnt), 32'd1);

        // Three starved pixels mid-line; clear collides with the second one.
        tgt = 4 * HT + 7;
        while (pos_m != tgt - 1) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("uf_after_collision", 32'(oUNDERFLOW), 32'd1);
        wait_run_at_origin("resync");
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("uf_after_clear", 32'(oUNDERFLOW), 32'd0);
        repeat (FT) step(1'b0, 1'b0);

        // Random starvation, clears and data.
        rand_data = 1'b1;
        repeat (5 * FT) step($urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0);

        // Asynchronous reset inside the active area.
        rand_data = 1'b0;
        wait_run_at_origin("pre_reset");
        tgt = 5 * HT + 10;
        while (pos_m != tgt) step(1'b0, 1'b0);
        mon_en  = 1'b0;
        RESET_N = 1'b0;
        #1;
        chk_reset_outputs("midframe");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        pos_m = 0; run_m = 1'b0; miss_m = 1'b0; uf_m = 1'b0;
        exp_q.push_back(reset_entry());
        exp_q.push_back(reset_entry());
        mon_en  = 1'b1;
        RESET_N = 1'b1;
        repeat (2 * FT) step(1'b0, 1'b0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule

// File: doc/ltm_disp_reader.md
Name: ltm_disp_reader

Overview:
- Display-side reader for the DISP_FIFO that the SRAM controller fills, i.e. the consuming end of the display FIFO interface.
- Generates LTM panel timing (800x480, 1056x525 total) with H/V counters.
- Pops one 24-bit RGB word per active pixel and drives registered RGB, HD, VD and DEN to the LTM.
- Runs in the FIFO read clock domain (DISP_FIFO_RDCLK); detects FIFO underflow and resynchronises on frame boundaries.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FRONT, 40, front porch clocks
H_SYNC, 1, HD low pulse clocks
H_BACK, 215, back porch clocks (H total = 1056)
V_ACTIVE, 480, visible lines
V_FRONT, 10, front porch lines
V_SYNC, 1, VD low pulse lines
V_BACK, 34, back porch lines (V total = 525)
BLANK_RGB, 24'h000000, RGB driven outside active area and on underflow

Ports:
CLK  in  1  pixel clock, same net as DISP_FIFO_RDCLK
RESET_N  in  1  asynchronous active-low reset
iFIFO_DATA  in  24  DISP_FIFO q, {R,G,B}; normal (non-show-ahead) mode
iFIFO_EMPTY  in  1  DISP_FIFO rdempty
oFIFO_RD  out  1  DISP_FIFO rdreq
iCLR_ERR  in  1  clears oUNDERFLOW
oLCD_R  out  8  red
oLCD_G  out  8  green
oLCD_B  out  8  blue
oHD  out  1  horizontal sync, active low
oVD  out  1  vertical sync, active low
oDEN  out  1  data enable, high during active pixels
oFRAME_START  out  1  one-cycle pulse aligned with the first active pixel of a frame
oUNDERFLOW  out  1  sticky underflow flag

Behaviour:
- Reset (asynchronous, RESET_N low):
  - Counters h_cnt = v_cnt = 0; state = WAIT_SYNC.
  - oFIFO_RD = 0; oLCD_* = BLANK_RGB; oHD = oVD = 1; oDEN = 0; oFRAME_START = 0; oUNDERFLOW = 0.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
  - Line and frame regions are ordered sync, back porch, active, front porch.
  - Active pixel: H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE, and likewise for v_cnt.
- Decoded timing: hd_d = (h_cnt < H_SYNC) ? 0 : 1; vd_d is the same on v_cnt; den_d = active pixel.
- State machine:
  - WAIT_SYNC: oFIFO_RD held 0; RGB forced to BLANK_RGB; syncs still toggle. Move to RUN when h_cnt = 0, v_cnt = 0 and iFIFO_EMPTY = 0.
  - RUN: oFIFO_RD = den_d & ~iFIFO_EMPTY (combinational).
  - Underflow: den_d & iFIFO_EMPTY in RUN sets oUNDERFLOW and the internal miss flag. That pixel outputs BLANK_RGB and no read is issued.
  - At end of frame (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1), if miss is set, go to WAIT_SYNC and clear miss.
- Latency:
  - rdreq at cycle t gives q valid in cycle t+1, registered into oLCD_* at the end of t+1, so data is visible at t+2.
  - hd_d, vd_d, den_d and frame-start decode each pass through a 2-stage delay so they align exactly with RGB.
  - Output RGB = BLANK_RGB unless the delayed den is 1 and a read was issued 2 cycles earlier (tracked by a 2-stage valid shift).
- oFRAME_START: delayed decode of (h_cnt, v_cnt) = (first active pixel, first active line) while in RUN.
- oUNDERFLOW: set has priority over iCLR_ERR when both occur in the same cycle; otherwise iCLR_ERR clears it.
- Exactly H_ACTIVE*V_ACTIVE = 384000 reads per underflow-free frame; never reads when iFIFO_EMPTY = 1.
- Reset mid-frame: all outputs return to reset values immediately; the block re-enters WAIT_SYNC with the FIFO untouched. The FIFO aclr is driven separately.

Decomposition:
- Shared package: ltm_timing_pkg with H_*/V_* defaults, derived H_TOTAL and V_TOTAL, and the state encoding (WAIT_SYNC, RUN). The SRAM controller can reuse DISPLAY_WIDTH/HEIGHT from it.
- One sub-module: ltm_timing_gen, holding the counters plus hd_d, vd_d, den_d and frame-start decode. The FIFO, pipeline and state logic stay in the top module.

Test Plan:
- Reset, FIFO permanently empty -> oHD low for 1 clock every 1056; oVD low for 1 line every 525 lines; oDEN always 0; oFIFO_RD always 0; RGB 000000.
- FIFO model pre-filled with an incrementing pattern, kept non-empty -> RUN entered at frame start; first oDEN cycle shows 000000, then 000001; 800 consecutive DEN cycles per line; 384000 reads per frame; oFRAME_START pulses once per frame on DEN's first cycle.
- Force iFIFO_EMPTY = 1 for 3 cycles mid-line in RUN -> oFIFO_RD 0 for those cycles; 3 BLANK_RGB pixels with oDEN still 1; oUNDERFLOW = 1; WAIT_SYNC entered after frame end; next frame starts cleanly.
- Underflow and iCLR_ERR in the same cycle -> oUNDERFLOW stays 1; iCLR_ERR alone later -> oUNDERFLOW = 0.
- Assert RESET_N low at h_cnt = 500, v_cnt = 200 -> all outputs take reset values in the same cycle; after release, no reads until the next (0,0) with the FIFO non-empty.
- Check the 2-cycle alignment: a word popped at rdreq cycle t appears on oLCD_* exactly in the cycle where the delayed oDEN for that pixel position is high.
